fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 66 ++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with decode handshake, timeout and misalignment fault
// Ports: clk, clr (async active-low reset); pc_val/stall/flush from PC stage;
//        mem_req/mem_addr/mem_ack/mem_rdata to instruction memory;
//        instr/instr_pc/instr_valid/instr_ready to decode; pc_inc advance pulse; fetch_err sticky fault.
module fetch_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] pc_val,
   input  logic        stall,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        pc_inc,
   output logic        fetch_err
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;
   state_t state, state_nxt;
   logic [7:0] cnt;
   logic start, done;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (!flush && !stall) state_nxt = (pc_val[1:0] == 2'b00) ? REQ : ERR;
         REQ:  state_nxt = flush ? IDLE : mem_ack ? HOLD : (cnt == 8'(TIMEOUT - 1)) ? ERR : REQ;
         HOLD: state_nxt = (flush || instr_ready) ? IDLE : HOLD;
         ERR:  state_nxt = flush ? IDLE : ERR;
      endcase
   end
   assign start = (state == IDLE) && (state_nxt == REQ);
   // flush is already folded into state_nxt, so an ack under flush never completes a fetch
   assign done  = (state == REQ) && (state_nxt == HOLD);
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= IDLE;
         cnt      <= '0;
         mem_addr <= '0;
         instr    <= '0;
         instr_pc <= '0;
         pc_inc   <= 1'b0;
      end else begin
         state  <= state_nxt;
         pc_inc <= done;
         if (start) begin
            mem_addr <= pc_val;
            cnt      <= '0;
         end else if (state == REQ && !mem_ack) begin
            cnt <= cnt + 8'd1;
         end
         if (done) begin
            instr    <= mem_rdata;
            instr_pc <= mem_addr;
         end
      end
   end
   assign mem_req     = (state == REQ);
   assign instr_valid = (state == HOLD);
   assign fetch_err   = (state == ERR);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] pc_val = '0;
   logic        stall = 1'b1;
   logic        flush = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        pc_inc;
   logic        fetch_err;
   int total = 0;
   int bad = 0;
   int pulses = 0;
   fetch_unit #(.TIMEOUT(16)) dut (
      .clk(clk), .clr(clr), .pc_val(pc_val), .stall(stall), .flush(flush),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .pc_inc(pc_inc), .fetch_err(fetch_err)
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (pc_inc) pulses++;
   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic test_reset;
      clr = 1'b0;
      step;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
      total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr got %h want 0", instr); end
      total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_instr_pc got %h want 0", instr_pc); end
      total++; if ({instr_valid, pc_inc, fetch_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", {instr_valid, pc_inc, fetch_err}); end
      clr = 1'b1;
      step;
   endtask
   task automatic test_single;
      pulses = 0;
      pc_val = 32'h0; stall = 1'b0; instr_ready = 1'b1;
      step;
      stall = 1'b1;
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL single_req got %b want 1", mem_req); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL single_addr got %h want 0", mem_addr); end
      step;
      step;
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL single_req_wait got %b want 1", mem_req); end
      mem_ack = 1'b1; mem_rdata = 32'h00500093;
      step;
      mem_ack = 1'b0;
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL single_valid got %b want 1", instr_valid); end
      total++; if (instr !== 32'h00500093) begin bad++; $display("FAIL single_instr got %h want 00500093", instr); end
      total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL single_instr_pc got %h want 0", instr_pc); end
      total++; if (pc_inc !== 1'b1) begin bad++; $display("FAIL single_pc_inc got %b want 1", pc_inc); end
      step;
      total++; if ({instr_valid, pc_inc, mem_req} !== 3'b000) begin bad++; $display("FAIL single_accept got %b want 000", {instr_valid, pc_inc, mem_req}); end
      step;
      total++; if (pulses !== 1) begin bad++; $display("FAIL single_pulses got %0d want 1", pulses); end
   endtask
   task automatic test_back_to_back;
      int req_cyc[$];
      logic [31:0] got_instr[$];
      logic [31:0] got_pc[$];
      pulses = 0;
      pc_val = 32'h0; stall = 1'b0; instr_ready = 1'b1; mem_ack = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         mem_rdata = (mem_addr == 32'h4) ? 32'h00a00113 : 32'h00500093;
         step;
         if (i == 1) pc_val = 32'h4;
         if (i == 6) stall = 1'b1;
         if (mem_req) req_cyc.push_back(i);
         if (instr_valid) begin got_instr.push_back(instr); got_pc.push_back(instr_pc); end
      end
      mem_ack = 1'b0;
      total++; if (req_cyc.size() != 2) begin bad++; $display("FAIL b2b_req_count got %0d want 2", req_cyc.size()); end
      else begin
         total++; if (req_cyc[1] - req_cyc[0] != 3) begin bad++; $display("FAIL b2b_spacing got %0d want 3", req_cyc[1] - req_cyc[0]); end
      end
      total++; if (pulses !== 2) begin bad++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
      total++; if (got_instr.size() != 2) begin bad++; $display("FAIL b2b_fetches got %0d want 2", got_instr.size()); end
      else begin
         total++; if (got_instr[0] !== 32'h00500093 || got_pc[0] !== 32'h0) begin bad++; $display("FAIL b2b_first got %h@%h want 00500093@00000000", got_instr[0], got_pc[0]); end
         total++; if (got_instr[1] !== 32'h00a00113 || got_pc[1] !== 32'h4) begin bad++; $display("FAIL b2b_second got %h@%h want 00a00113@00000004", got_instr[1], got_pc[1]); end
      end
   endtask
   task automatic test_hold;
      pulses = 0;
      pc_val = 32'h8; stall = 1'b0; instr_ready = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hdeadbeef;
      step;
      step;
      mem_ack = 1'b0; pc_val = 32'hc;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) stall = 1'b1;
         total++; if (instr_valid !== 1'b1 || instr !== 32'hdeadbeef || instr_pc !== 32'h8 || mem_req !== 1'b0) begin
            bad++; $display("FAIL hold_stable got v=%b i=%h pc=%h req=%b want v=1 i=deadbeef pc=00000008 req=0", instr_valid, instr, instr_pc, mem_req);
         end
         step;
      end
      instr_ready = 1'b1;
      step;
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL hold_release got %b want 0", instr_valid); end
      total++; if (pulses !== 1) begin bad++; $display("FAIL hold_pulses got %0d want 1", pulses); end
   endtask
   task automatic test_timeout;
      int n;
      pc_val = 32'h10; stall = 1'b0; mem_ack = 1'b0;
      step;
      stall = 1'b1;
      n = 0;
      for (int i = 0; i < 40 && mem_req; i++) begin
         n++;
         step;
      end
      total++; if (n != 16) begin bad++; $display("FAIL timeout_req_cycles got %0d want 16", n); end
      total++; if (fetch_err !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL timeout_err got err=%b req=%b want err=1 req=0", fetch_err, mem_req); end
      step;
      total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky got %b want 1", fetch_err); end
      flush = 1'b1;
      step;
      flush = 1'b0;
      total++; if ({fetch_err, mem_req, instr_valid} !== 3'b000) begin bad++; $display("FAIL timeout_flush got %b want 000", {fetch_err, mem_req, instr_valid}); end
   endtask
   task automatic test_misaligned;
      int saw_req;
      pulses = 0; saw_req = 0;
      pc_val = 32'h6; stall = 1'b0;
      step;
      stall = 1'b1;
      if (mem_req) saw_req++;
      total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL misaligned_err got %b want 1", fetch_err); end
      for (int i = 0; i < 3; i++) begin step; if (mem_req) saw_req++; end
      total++; if (saw_req != 0 || pulses != 0) begin bad++; $display("FAIL misaligned_noreq got req=%0d inc=%0d want 0 0", saw_req, pulses); end
      flush = 1'b1;
      step;
      flush = 1'b0;
      total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL misaligned_clear got %b want 0", fetch_err); end
   endtask
   task automatic test_flush_ack;
      pulses = 0;
      pc_val = 32'h20; stall = 1'b0; instr_ready = 1'b1;
      step;
      mem_ack = 1'b1; mem_rdata = 32'h12345678; flush = 1'b1; stall = 1'b1;
      step;
      mem_ack = 1'b0; flush = 1'b0;
      total++; if ({instr_valid, pc_inc, mem_req} !== 3'b000) begin bad++; $display("FAIL flush_ack_flags got %b want 000", {instr_valid, pc_inc, mem_req}); end
      total++; if (instr !== 32'hdeadbeef || instr_pc !== 32'h8) begin bad++; $display("FAIL flush_ack_instr got %h@%h want deadbeef@00000008", instr, instr_pc); end
      step;
      total++; if (pulses !== 0) begin bad++; $display("FAIL flush_ack_pulses got %0d want 0", pulses); end
   endtask
   task automatic test_reset_mid;
      pc_val = 32'h40; stall = 1'b0;
      step;
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rmid_req got %b want 1", mem_req); end
      #2 clr = 1'b0;
      #1;
      total++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
         bad++; $display("FAIL rmid_async got req=%b addr=%h i=%h pc=%h want 0", mem_req, mem_addr, instr, instr_pc);
      end
      total++; if ({instr_valid, pc_inc, fetch_err} !== 3'b000) begin bad++; $display("FAIL rmid_flags got %b want 000", {instr_valid, pc_inc, fetch_err}); end
      mem_ack = 1'b1; mem_rdata = 32'hcafef00d;
      step;
      clr = 1'b1; stall = 1'b1;
      step;
      total++; if ({mem_req, instr_valid, pc_inc} !== 3'b000 || instr !== 32'h0) begin bad++; $display("FAIL rmid_ignore got %b i=%h want 000 i=0", {mem_req, instr_valid, pc_inc}, instr); end
      mem_ack = 1'b0; stall = 1'b0; pc_val = 32'h44;
      step;
      stall = 1'b1;
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin bad++; $display("FAIL rmid_refetch got req=%b addr=%h want 1 00000044", mem_req, mem_addr); end
      mem_ack = 1'b1; mem_rdata = 32'h00000013;
      step;
      mem_ack = 1'b0;
      total++; if (instr_valid !== 1'b1 || instr !== 32'h13 || instr_pc !== 32'h44 || pc_inc !== 1'b1) begin
         bad++; $display("FAIL rmid_fetch got v=%b i=%h pc=%h inc=%b want 1 00000013 00000044 1", instr_valid, instr, instr_pc, pc_inc);
      end
      step;
   endtask
   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_hold;
      test_timeout;
      test_misaligned;
      test_flush_ack;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
